// File: rtl/uart_tx_arb_if.sv
// AXI4-Stream bundle between the byte requesters, the arbiter and the UART transmitter.
// master: the arbiter's view; slave: the surrounding requesters/transmitter.
interface uart_tx_arb_if #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8
);
    logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [PORTS-1:0]            s_axis_tvalid;
    logic [PORTS-1:0]            s_axis_tlast;
    logic [PORTS-1:0]            s_axis_tready;
    logic [DATA_WIDTH-1:0]       m_axis_tdata;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among PORTS byte streams.
// Optional UART_ARB_HEADER_EN: prefix every packet with the granted port index.
module uart_tx_arb #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arb_if.master    bus,
    output logic [PORTS-1:0] grant,
    output logic             busy
);
    localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef UART_ARB_HEADER_EN
        ST_HDR  = 2'd1,
`endif
        ST_PASS = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [PTR_W-1:0]        ptr_r;
    logic [PTR_W-1:0]        gidx_r;
    logic [PORTS-1:0]        grant_r;
    logic [PTR_W-1:0]        sel_s;
    logic [PTR_W:0]          scan_s;
    logic                    found_s;
    logic                    out_free_s;
    logic                    start_s;
    logic                    in_hs_s;
    logic                    in_last_s;
    logic [PORTS-1:0]        tready_s;
    logic                    load_s;
    logic [DATA_WIDTH-1:0]   load_data_s;
    logic                    m_valid_r;
    logic [DATA_WIDTH-1:0]   m_data_r;

    // The output register can take a byte when empty or draining this cycle.
    assign out_free_s = !m_valid_r || bus.m_axis_tready;
`ifdef UART_ARB_HEADER_EN
    // The header is loaded at grant time, so granting must wait for a free register.
    assign start_s    = (state_r == ST_IDLE) && found_s && out_free_s;
`else
    assign start_s    = (state_r == ST_IDLE) && found_s;
`endif
    assign in_hs_s    = (state_r == ST_PASS) && out_free_s && bus.s_axis_tvalid[gidx_r];
    assign in_last_s  = in_hs_s && bus.s_axis_tlast[gidx_r];

    // Round-robin scan: first requester at or after ptr, wrapping at PORTS-1.
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        scan_s  = '0;
        for (int i = 0; i < PORTS; i++) begin
            scan_s = {1'b0, ptr_r} + (PTR_W+1)'(i);
            if (scan_s >= (PTR_W+1)'(PORTS)) begin
                scan_s = scan_s - (PTR_W+1)'(PORTS);
            end else begin
                scan_s = scan_s;
            end
            if (!found_s && bus.s_axis_tvalid[scan_s[PTR_W-1:0]]) begin
                found_s = 1'b1;
                sel_s   = scan_s[PTR_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
`ifdef UART_ARB_HEADER_EN
                    state_nx_s = ST_HDR;
`else
                    state_nx_s = ST_PASS;
`endif
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
`ifdef UART_ARB_HEADER_EN
            ST_HDR: begin
                if (m_valid_r && bus.m_axis_tready) begin
                    state_nx_s = ST_PASS;
                end else begin
                    state_nx_s = ST_HDR;
                end
            end
`endif
            ST_PASS: begin
                if (in_last_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_PASS;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs: per-port ready and output-register load source.
    always_comb begin
        tready_s    = '0;
        load_s      = 1'b0;
        load_data_s = '0;
        case (state_r)
            ST_IDLE: begin
`ifdef UART_ARB_HEADER_EN
                if (start_s) begin
                    load_s      = 1'b1;
                    load_data_s = DATA_WIDTH'(sel_s);
                end else begin
                    load_s      = 1'b0;
                end
`else
                load_s = 1'b0;
`endif
            end
            ST_PASS: begin
                if (out_free_s) begin
                    tready_s = grant_r;
                end else begin
                    tready_s = '0;
                end
                load_s      = in_hs_s;
                load_data_s = bus.s_axis_tdata[gidx_r*DATA_WIDTH +: DATA_WIDTH];
            end
            default: begin
                tready_s = '0;
                load_s   = 1'b0;
            end
        endcase
    end

    // Grant ownership and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_r <= '0;
            gidx_r  <= '0;
            ptr_r   <= '0;
        end else if (start_s) begin
            grant_r <= {{(PORTS-1){1'b0}}, 1'b1} << sel_s;
            gidx_r  <= sel_s;
        end else if (in_last_s) begin
            grant_r <= '0;
            ptr_r   <= (gidx_r == PTR_W'(PORTS-1)) ? '0 : gidx_r + PTR_W'(1);
        end
    end

    // One-entry output register: a same-cycle load wins over the drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
        end else if (load_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= load_data_s;
        end else if (bus.m_axis_tready) begin
            m_valid_r <= 1'b0;
        end
    end

    assign grant             = grant_r;
    assign busy              = (state_r != ST_IDLE) || m_valid_r;
    assign bus.s_axis_tready = tready_s;
    assign bus.m_axis_tdata  = m_data_r;
    assign bus.m_axis_tvalid = m_valid_r;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: per-port packet drivers, expected-byte queue, output monitor.
module tb_uart_tx_arb;
    localparam int PORTS = 4;
    localparam int DW    = 8;
`ifdef UART_ARB_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [PORTS-1:0] grant;
    logic             busy;

    uart_tx_arb_if #(.PORTS(PORTS), .DATA_WIDTH(DW)) bus ();

    uart_tx_arb #(.PORTS(PORTS), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_q[$];
    logic [12:0] pq[PORTS][$];   // {gap[3:0], last, data}
    int          gap_cnt[PORTS];
    logic [PORTS-1:0] hs;
    logic [12:0] fe;
    logic [7:0]  mexp;
    int          cyc = 0;
    int          mode = 0;       // 0: tready=1, 1: 1 high / 3 low, 2: tready=0

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Requester and transmitter-side driver: changes inputs 1 time unit after each rising edge.
    initial begin
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tlast  = '0;
        bus.m_axis_tready = 1'b1;
        for (int p = 0; p < PORTS; p++) gap_cnt[p] = 0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < PORTS; p++) hs[p] = bus.s_axis_tvalid[p] && bus.s_axis_tready[p];
            @(posedge clk);
            #1;
            cyc++;
            for (int p = 0; p < PORTS; p++) begin
                if (hs[p] && pq[p].size() > 0) begin
                    fe = pq[p].pop_front();
                    if (pq[p].size() > 0) begin
                        fe = pq[p][0];
                        gap_cnt[p] = int'(fe[12:9]);
                    end
                end
                if (gap_cnt[p] > 0) begin
                    gap_cnt[p]--;
                    bus.s_axis_tvalid[p] = 1'b0;
                end else if (pq[p].size() > 0) begin
                    fe = pq[p][0];
                    bus.s_axis_tvalid[p]         = 1'b1;
                    bus.s_axis_tlast[p]          = fe[8];
                    bus.s_axis_tdata[p*DW +: DW] = fe[7:0];
                end else begin
                    bus.s_axis_tvalid[p] = 1'b0;
                end
            end
            bus.m_axis_tready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 4) == 0) : 1'b0;
        end
    end

    // Monitor: compare each transmitted byte against the scoreboard and check backpressure.
    always @(negedge clk) begin
        if (rst_n && bus.m_axis_tvalid && bus.m_axis_tready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got %0h expected none", bus.m_axis_tdata);
            end else begin
                mexp = exp_q.pop_front();
                chk("m_axis_tdata", {24'd0, bus.m_axis_tdata}, {24'd0, mexp});
            end
        end
        if (rst_n && bus.m_axis_tvalid && !bus.m_axis_tready)
            chk("tready_while_full", {28'd0, bus.s_axis_tready}, 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input int p, input logic [7:0] d, input bit last, input int gap, input bit ex);
        pq[p].push_back({gap[3:0], last, d});
        if (ex) exp_q.push_back(d);
    endtask

    task automatic hdr(input int p);
        if (HDR != 0) exp_q.push_back(8'(p));
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size() != 0 ||
                exp_q.size() != 0 || busy) && n < 500) begin
            step();
            n++;
        end
        chk(nm, {31'd0, n < 500}, 32'd1);
    endtask

    task automatic grant_window(input string nm, input logic [3:0] g, input int cycles);
        int gc = 0;
        int n  = 0;
        bit seen = 1'b0;
        while (n < 300 && !(seen && grant == 4'd0)) begin
            @(negedge clk);
            n++;
            if (grant != 4'd0) begin
                seen = 1'b1;
                gc++;
                chk(nm, {28'd0, grant}, {28'd0, g});
            end
        end
        chk({nm, "_cycles"}, gc, cycles);
        step();
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_grant"},  {28'd0, grant}, 32'd0);
        chk({nm, "_tready"}, {28'd0, bus.s_axis_tready}, 32'd0);
        chk({nm, "_mvalid"}, {31'd0, bus.m_axis_tvalid}, 32'd0);
        chk({nm, "_mdata"},  {24'd0, bus.m_axis_tdata}, 32'd0);
        chk({nm, "_busy"},   {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int cnt;
        repeat (3) step();
        @(negedge clk);
        check_reset("reset");
        step();
        rst_n = 1'b1;
        step();

        // Round robin from ptr=0: every port queues two 2-byte packets.
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < PORTS; p++) begin
                hdr(p);
                put(p, 8'(p*16),     1'b0, 0, 1'b1);
                put(p, 8'(p*16 + 1), 1'b1, 0, 1'b1);
            end
        end
        wait_drain("rr_drain");

        // Single port, three consecutive bytes (ptr now 0).
        hdr(0);
        put(0, 8'h41, 1'b0, 0, 1'b1);
        put(0, 8'h42, 1'b0, 0, 1'b1);
        put(0, 8'h43, 1'b1, 0, 1'b1);
        grant_window("single_grant", 4'b0001, 3 + HDR);
        wait_drain("single_drain");
        chk("single_grant_after", {28'd0, grant}, 32'd0);

        // Backpressure: 5-byte packet from port 3 with 1-high/3-low tready.
        mode = 1;
        hdr(3);
        for (int k = 1; k <= 5; k++) put(3, 8'(8'h30 + k), k == 5, 0, 1'b1);
        wait_drain("bp_drain");
        mode = 0;
        step();

        // Single-beat packet from port 2 (leaves ptr=3).
        hdr(2);
        put(2, 8'h2A, 1'b1, 0, 1'b1);
        grant_window("beat_grant", 4'b0100, 1 + HDR);
        wait_drain("beat_drain");

        // Wrap-around with a 10-cycle mid-packet stall on port 3.
        hdr(3);
        put(3, 8'h3A, 1'b0, 0, 1'b1);
        put(3, 8'h3B, 1'b0, 10, 1'b1);
        put(3, 8'h3C, 1'b1, 0, 1'b1);
        hdr(0);
        put(0, 8'h0A, 1'b1, 0, 1'b1);
        n = 0;
        while (grant == 4'd0 && n < 300) begin @(negedge clk); n++; end
        chk("wrap_first", {28'd0, grant}, 32'h8);
        cnt = 0;
        while (grant == 4'b1000 && n < 300) begin cnt++; @(negedge clk); n++; end
        chk("wrap_hold_cycles", cnt, 13 + HDR);
        cnt = 0;
        while (grant == 4'd0 && n < 300) begin cnt++; @(negedge clk); n++; end
        chk("wrap_gap", cnt, 1);
        chk("wrap_next", {28'd0, grant}, 32'h1);
        step();
        wait_drain("wrap_drain");

        // Reset mid-packet: port 1 granted with a full, stalled output register.
        mode = 2;
        step();
        put(1, 8'h1A, 1'b0, 0, 1'b0);
        put(1, 8'h1B, 1'b1, 0, 1'b0);
        n = 0;
        while (!bus.m_axis_tvalid && n < 50) begin @(negedge clk); n++; end
        chk("midrst_grant", {28'd0, grant}, 32'h2);
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        pq[1].delete();
        @(negedge clk);
        check_reset("midrst");
        step();
        rst_n = 1'b1;
        mode = 0;
        hdr(2);
        put(2, 8'h2B, 1'b1, 0, 1'b1);
        grant_window("postrst_grant", 4'b0100, 1 + HDR);
        wait_drain("postrst_drain");

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
